fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter AW, default 8, instruction address width.
REQ-002 SHALL have parameter IW, default 16, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mem_req  output  1  fetch request strobe, one cycle per request.
REQ-007 SHALL have port mem_addr  output  AW  fetch address, valid while mem_req=1.
REQ-008 SHALL have port mem_valid  input  1  read data valid for the oldest outstanding request.
REQ-009 SHALL have port mem_rdata  input  IW  read data, sampled when mem_valid=1.
REQ-010 SHALL have port done  input  1  control-unit pulse: current instruction retired.
REQ-011 SHALL have port jump_en  input  1  redirect strobe, one cycle.
REQ-012 SHALL have port jump_addr  input  AW  redirect target, sampled when jump_en=1.
REQ-013 SHALL have port inst  output  IW  instruction presented to control unit, registered.
REQ-014 SHALL have port inst_valid  output  1  inst holds a valid instruction; low means control unit stalls.
REQ-015 SHALL have port pc  output  AW  address of the instruction currently on inst.

Function
REQ-016 SHALL hold a 2-entry in-order instruction queue (head drives inst/pc) plus fetch pointer fpc.
REQ-017 SHALL assert mem_req combinationally when no request is outstanding, queue count < 2, jump_en=0, reset=0; mem_addr = fpc.
REQ-018 SHALL permit at most one outstanding request; outstanding sets on mem_req, clears on mem_valid.
REQ-019 SHALL increment fpc by 1 on each issued request, wrapping 2^AW-1 -> 0.
REQ-020 SHALL append {mem_rdata, request address} to the queue on mem_valid unless the discard flag is set.
REQ-021 SHALL pop the head on an edge where done=1 and inst_valid=1; next entry appears on inst on that same edge (zero bubble when queue held 2).
REQ-022 SHALL handle push and pop on the same edge with count unchanged and order preserved.
REQ-023 SHALL ignore done while inst_valid=0.
REQ-024 SHALL keep inst and pc stable while inst_valid=1 and done=0.
REQ-025 On jump_en=1: SHALL flush queue (inst_valid=0 next cycle), set fpc=jump_addr, set discard flag if a request is outstanding and mem_valid=0 that cycle.
REQ-026 SHALL drop a mem_valid response arriving on the same edge as jump_en=1.
REQ-027 SHALL clear the discard flag when the discarded response arrives; no push that cycle.
REQ-028 SHALL give jump_en priority over done and over mem_valid on the same edge.
REQ-029 Latency: instruction on inst/inst_valid=1 exactly one cycle after its mem_valid when queue was empty.

Reset
REQ-030 On reset=1: inst=0, inst_valid=0, pc=RESET_PC, fpc=RESET_PC, queue count=0, outstanding=0, discard=0, mem_req=0.
REQ-031 Reset mid-fetch SHALL abandon the outstanding request; a mem_valid during or after reset for it SHALL NOT be pushed (memory is reset in the same domain).
REQ-032 First mem_req SHALL occur in the first cycle with reset=0, mem_addr=RESET_PC.

Structure
REQ-033 AW, IW, RESET_PC default and instruction/address typedefs SHALL live in shared package bitty_pkg.
REQ-034 The 2-entry queue SHALL be sub-module fetch_queue (push, pop, flush, count, head); FSM/pointer logic in fetch_unit.

Verification
REQ-035 Reset release, memory latency 1, mem[0]=16'h2A05 -> mem_req addr 0 cycle 0; inst=16'h2A05, pc=0, inst_valid=1 cycle 2.
REQ-036 done pulses every 3 cycles, mem[0..3] distinct -> inst sequence mem[0..3] in order, pc 0,1,2,3, no duplicates/skips.
REQ-037 jump_en addr 8'h40 while request to addr 5 outstanding -> addr 5 data dropped, next mem_req addr 8'h40, inst=mem[0x40].
REQ-038 fpc at 8'hFF, no jump -> fetch 8'hFF then 8'h00; pc wraps to 0.
REQ-039 Queue full, done and mem_valid blocked, then done with jump_en same cycle -> flush, inst_valid=0, next fetch at jump_addr.
REQ-040 reset asserted with request outstanding and mem_valid arriving next cycle -> queue empty, inst_valid=0, restart fetch at RESET_PC.

Source files
------------

// File: rtl/bitty_pkg.sv
// ---------------------------------------------------------------------------
// bitty_pkg
// Shared definitions for the bitty instruction fetch path.
//   DEF_AW        default instruction address width
//   DEF_IW        default instruction width
//   DEF_RESET_PC  default first fetch address after reset
//   addr_t/inst_t address and instruction types at the default widths
//   fetch_state_e state of the single-outstanding memory request tracker
// ---------------------------------------------------------------------------
package bitty_pkg;

   localparam int          DEF_AW       = 8;
   localparam int          DEF_IW       = 16;
   localparam int unsigned DEF_RESET_PC = 0;

   typedef logic [DEF_AW-1:0] addr_t;
   typedef logic [DEF_IW-1:0] inst_t;

   // FETCH_DROP means a request is still in flight but its data belongs to a
   // path that was abandoned by a jump, so it must be swallowed on arrival.
   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Two-entry in-order queue of {instruction, address} pairs. The head entry is
// held in flops and drives the control unit directly.
//   clk, reset          clock, synchronous active-high reset
//   flush               drop every entry (takes priority over push/pop)
//   push, push_inst,
//   push_addr           append an entry at the tail
//   pop                 remove the head entry
//   count               number of valid entries (0..2)
//   head_inst/head_addr contents of the head entry
// ---------------------------------------------------------------------------
module fetch_queue
   import bitty_pkg::*;
#(
   parameter int          AW       = DEF_AW,
   parameter int          IW       = DEF_IW,
   parameter int unsigned RESET_PC = DEF_RESET_PC
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic [IW-1:0] push_inst,
   input  logic [AW-1:0] push_addr,
   input  logic          pop,
   output logic [1:0]    count,
   output logic [IW-1:0] head_inst,
   output logic [AW-1:0] head_addr
);

   logic [1:0]    count_q, count_d;
   logic [IW-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
   logic [AW-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
   logic          push_ok, pop_ok;

   // Slot 0 is always the head. A pop shifts slot 1 down; a push lands in the
   // first free slot after any pop on the same edge, so order is preserved and
   // a simultaneous push/pop on a one-entry queue puts the new entry straight
   // on the head. Data is not cleared on flush; count alone decides validity.
   always_comb begin
      count_d = count_q;
      inst0_d = inst0_q;
      inst1_d = inst1_q;
      addr0_d = addr0_q;
      addr1_d = addr1_q;
      pop_ok  = pop && (count_q != 2'd0);
      push_ok = push && ((count_q != 2'd2) || pop_ok);
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count_q == 2'd0) begin
                  inst0_d = push_inst;
                  addr0_d = push_addr;
               end else begin
                  inst1_d = push_inst;
                  addr1_d = push_addr;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               inst0_d = inst1_q;
               addr0_d = addr1_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  inst0_d = push_inst;
                  addr0_d = push_addr;
               end else begin
                  inst0_d = inst1_q;
                  addr0_d = addr1_q;
                  inst1_d = push_inst;
                  addr1_d = push_addr;
               end
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
   end

   // Queue storage; reset leaves the head showing a zero instruction at the
   // reset address so pc is meaningful even before the first fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 2'd0;
         inst0_q <= '0;
         inst1_q <= '0;
         addr0_q <= AW'(RESET_PC);
         addr1_q <= AW'(RESET_PC);
      end else begin
         count_q <= count_d;
         inst0_q <= inst0_d;
         inst1_q <= inst1_d;
         addr0_q <= addr0_d;
         addr1_q <= addr1_d;
      end
   end

   assign count     = count_q;
   assign head_inst = inst0_q;
   assign head_addr = addr0_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: issues one memory read at a time, buffers up to
// two returned instructions and presents the oldest to the control unit.
//   clk, reset           clock, synchronous active-high reset
//   mem_req, mem_addr    read request strobe and address (combinational)
//   mem_valid, mem_rdata read response for the outstanding request
//   done                 control unit retired the instruction on inst
//   jump_en, jump_addr   redirect fetch; flushes buffered instructions
//   inst, inst_valid, pc instruction, its validity and its address
// ---------------------------------------------------------------------------
module fetch_unit
   import bitty_pkg::*;
#(
   parameter int          AW       = DEF_AW,
   parameter int          IW       = DEF_IW,
   parameter int unsigned RESET_PC = DEF_RESET_PC
) (
   input  logic          clk,
   input  logic          reset,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_valid,
   input  logic [IW-1:0] mem_rdata,
   input  logic          done,
   input  logic          jump_en,
   input  logic [AW-1:0] jump_addr,
   output logic [IW-1:0] inst,
   output logic          inst_valid,
   output logic [AW-1:0] pc
);

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] fpc_q, fpc_d;
   logic [AW-1:0] req_addr_q, req_addr_d;
   logic [1:0]    q_count;
   logic          q_push, q_pop, q_flush;

   // Request tracking and fetch pointer. A request only goes out when nothing
   // is in flight and the queue has room for its answer, so the queue can
   // never overflow. A jump wins over everything: it flushes, retargets the
   // fetch pointer and, if the in-flight answer has not arrived yet, marks it
   // for dropping. The address of each request is kept so the returned
   // instruction can be tagged with its own pc.
   always_comb begin
      state_d    = state_q;
      fpc_d      = fpc_q;
      req_addr_d = req_addr_q;
      q_push     = 1'b0;
      q_pop      = 1'b0;
      q_flush    = 1'b0;
      mem_req    = (state_q == FETCH_IDLE) && (q_count != 2'd2) && !jump_en && !reset;
      if (jump_en) begin
         q_flush = 1'b1;
         fpc_d   = jump_addr;
         if (state_q != FETCH_IDLE) begin
            state_d = mem_valid ? FETCH_IDLE : FETCH_DROP;
         end
      end else begin
         q_pop = done && inst_valid;
         case (state_q)
            FETCH_IDLE: begin
               if (mem_req) begin
                  state_d    = FETCH_WAIT;
                  req_addr_d = fpc_q;
                  fpc_d      = fpc_q + AW'(1);
               end
            end
            FETCH_WAIT: begin
               if (mem_valid) begin
                  q_push  = 1'b1;
                  state_d = FETCH_IDLE;
               end
            end
            FETCH_DROP: begin
               if (mem_valid) begin
                  state_d = FETCH_IDLE;
               end
            end
            default: begin
               state_d = FETCH_IDLE;
            end
         endcase
      end
   end

   // State register. Reset abandons any in-flight request outright; since
   // the tracker returns to idle, a late answer for it is simply ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH_IDLE;
         fpc_q      <= AW'(RESET_PC);
         req_addr_q <= AW'(RESET_PC);
      end else begin
         state_q    <= state_d;
         fpc_q      <= fpc_d;
         req_addr_q <= req_addr_d;
      end
   end

   fetch_queue #(
      .AW       (AW),
      .IW       (IW),
      .RESET_PC (RESET_PC)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (q_flush),
      .push      (q_push),
      .push_inst (mem_rdata),
      .push_addr (req_addr_q),
      .pop       (q_pop),
      .count     (q_count),
      .head_inst (inst),
      .head_addr (pc)
   );

   assign mem_addr   = fpc_q;
   assign inst_valid = (q_count != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: a memory responder with configurable
// latency, a queue-based behavioural model compared every cycle, directed
// scenarios with literal expectations, then a randomized run.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int          AW       = 8;
   localparam int          IW       = 16;
   localparam int unsigned RESET_PC = 0;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_valid = 1'b0;
   logic [IW-1:0] mem_rdata = '0;
   logic          done = 1'b0;
   logic          jump_en = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic [IW-1:0] inst;
   logic          inst_valid;
   logic [AW-1:0] pc;

   fetch_unit #(
      .AW       (AW),
      .IW       (IW),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_valid  (mem_valid),
      .mem_rdata  (mem_rdata),
      .done       (done),
      .jump_en    (jump_en),
      .jump_addr  (jump_addr),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One call = one clock cycle of inputs, applied just after the edge.
   task automatic applyStimulus(input logic r, input logic d, input logic j, input logic [AW-1:0] ja);
      @(posedge clk);
      #1;
      reset     = r;
      done      = d;
      jump_en   = j;
      jump_addr = ja;
   endtask

   // Memory contents and responder controls.
   logic [IW-1:0] mem [0:255];
   int            lat      = 1;
   bit            rand_lat = 1'b0;
   bit            rsp_pend = 1'b0;
   int            rsp_wait = 0;
   logic [AW-1:0] rsp_addr = '0;
   bit            manual   = 1'b0;
   logic          man_valid = 1'b0;
   logic [IW-1:0] man_rdata = '0;
   logic          s_mem_req = 1'b0;
   logic [AW-1:0] s_mem_addr = '0;

   // Memory responder: latches a request seen in a cycle and answers it
   // 'lat' cycles later. It is reset along with the DUT. In manual mode the
   // bench drives mem_valid/mem_rdata itself to inject stale responses.
   always @(posedge clk) begin
      if (reset) begin
         rsp_pend = 1'b0;
      end else begin
         if (!manual && mem_valid && rsp_pend) begin
            rsp_pend = 1'b0;
         end else if (rsp_pend && rsp_wait > 0) begin
            rsp_wait--;
         end
         if (s_mem_req) begin
            rsp_pend = 1'b1;
            rsp_addr = s_mem_addr;
            rsp_wait = (rand_lat ? int'($urandom_range(3, 1)) : lat) - 1;
         end
      end
      #2;
      if (manual) begin
         mem_valid = man_valid;
         mem_rdata = man_rdata;
      end else begin
         mem_valid = rsp_pend && (rsp_wait == 0);
         mem_rdata = mem_valid ? mem[rsp_addr] : IW'($urandom);
      end
   end

   // Behavioural model: a plain queue of fetched instructions, the next
   // address to fetch, and a record of the single request in flight.
   typedef struct packed {
      logic [IW-1:0] ins;
      logic [AW-1:0] adr;
   } ent_t;

   ent_t          mq[$];
   int            m_fpc   = RESET_PC;
   bit            m_pend  = 1'b0;
   bit            m_drop  = 1'b0;
   logic [AW-1:0] m_paddr = '0;
   bit            m_fresh = 1'b1;

   function automatic bit modelReq();
      return !reset && !m_pend && (mq.size() < 2) && !jump_en;
   endfunction

   // Advance the model on each rising edge from the inputs held that cycle.
   always @(posedge clk) begin
      bit   req_now;
      bit   accept;
      ent_t e;
      req_now = modelReq();
      accept  = 1'b0;
      if (reset) begin
         mq.delete();
         m_fpc   = RESET_PC;
         m_pend  = 1'b0;
         m_drop  = 1'b0;
         m_fresh = 1'b1;
      end else begin
         if (mem_valid && m_pend) begin
            accept = !m_drop && !jump_en;
            m_pend = 1'b0;
            m_drop = 1'b0;
         end
         if (jump_en) begin
            mq.delete();
            if (m_pend) m_drop = 1'b1;
            m_fpc = int'(jump_addr);
         end else begin
            if (done && mq.size() > 0) void'(mq.pop_front());
            if (accept) begin
               e.ins = mem_rdata;
               e.adr = m_paddr;
               mq.push_back(e);
               m_fresh = 1'b0;
            end
            if (req_now) begin
               m_pend  = 1'b1;
               m_paddr = AW'(m_fpc);
               m_fpc   = (m_fpc + 1) % (1 << AW);
            end
         end
      end
   end

   // Every-cycle comparison against the model, on the falling edge.
   always @(negedge clk) begin
      s_mem_req  = mem_req;
      s_mem_addr = mem_addr;
      checkOutput("inst_valid", inst_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         checkOutput("inst", inst, mq[0].ins);
         checkOutput("pc", pc, mq[0].adr);
      end else if (m_fresh) begin
         checkOutput("inst_after_reset", inst, 0);
         checkOutput("pc_after_reset", pc, RESET_PC);
      end
      checkOutput("mem_req", mem_req, modelReq());
      if (modelReq()) checkOutput("mem_addr", mem_addr, m_fpc);
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [IW-1:0] ret_inst [4];
      logic [AW-1:0] ret_pc [4];
      logic [AW-1:0] req_seen [2];
      logic [IW-1:0] exp_seq [4];
      int            ret_cnt;
      int            req_cnt;
      bit            found;

      for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
      mem[0]    = 16'h2A05;
      mem[1]    = 16'h1111;
      mem[2]    = 16'h2222;
      mem[3]    = 16'h3333;
      mem[5]    = 16'h0505;
      mem[8'h40] = 16'hC0DE;
      mem[8'h80] = 16'h8080;
      mem[8'hFF] = 16'hFFFF;
      exp_seq[0] = 16'h2A05;
      exp_seq[1] = 16'h1111;
      exp_seq[2] = 16'h2222;
      exp_seq[3] = 16'h3333;

      // First fetch after reset with a one-cycle memory.
      lat = 1;
      repeat (3) applyStimulus(1, 0, 0, '0);
      @(negedge clk);
      checkOutput("reset_inst_valid", inst_valid, 0);
      checkOutput("reset_mem_req", mem_req, 0);
      applyStimulus(0, 0, 0, '0);
      @(negedge clk);
      checkOutput("first_req", mem_req, 1);
      checkOutput("first_addr", mem_addr, 8'h00);
      applyStimulus(0, 0, 0, '0);
      @(negedge clk);
      checkOutput("first_valid_c1", inst_valid, 0);
      applyStimulus(0, 0, 0, '0);
      @(negedge clk);
      checkOutput("first_valid_c2", inst_valid, 1);
      checkOutput("first_inst_c2", inst, 16'h2A05);
      checkOutput("first_pc_c2", pc, 8'h00);

      // Retire with done every third cycle; expect mem[0..3] in order.
      repeat (2) applyStimulus(1, 0, 0, '0);
      ret_cnt = 0;
      for (int c = 0; c < 40 && ret_cnt < 4; c++) begin
         applyStimulus(0, (c % 3) == 2, 0, '0);
         @(negedge clk);
         if (done && inst_valid) begin
            ret_inst[ret_cnt] = inst;
            ret_pc[ret_cnt]   = pc;
            ret_cnt++;
         end
      end
      checkOutput("seq_retired_count", ret_cnt, 4);
      for (int k = 0; k < 4; k++) begin
         if (k < ret_cnt) begin
            checkOutput("seq_inst", ret_inst[k], exp_seq[k]);
            checkOutput("seq_pc", ret_pc[k], k);
         end
      end

      // Jump to 0x40 while the request to address 5 is still in flight.
      lat = 3;
      repeat (2) applyStimulus(1, 0, 0, '0);
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         applyStimulus(0, 1, 0, '0);
         @(negedge clk);
         if (mem_req && mem_addr == 8'h05) found = 1'b1;
      end
      checkOutput("jmp_saw_req5", found, 1);
      applyStimulus(0, 0, 1, 8'h40);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         applyStimulus(0, 0, 0, '0);
         @(negedge clk);
         if (mem_req) begin
            found = 1'b1;
            checkOutput("jmp_next_addr", mem_addr, 8'h40);
         end
      end
      checkOutput("jmp_req_seen", found, 1);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         applyStimulus(0, 0, 0, '0);
         @(negedge clk);
         if (inst_valid) begin
            found = 1'b1;
            checkOutput("jmp_inst", inst, 16'hC0DE);
            checkOutput("jmp_pc", pc, 8'h40);
         end
      end
      checkOutput("jmp_inst_seen", found, 1);

      // Fetch pointer wrap from 0xFF to 0x00.
      lat = 1;
      repeat (2) applyStimulus(1, 0, 0, '0);
      applyStimulus(0, 1, 1, 8'hFF);
      req_cnt = 0;
      ret_cnt = 0;
      for (int c = 0; c < 30 && (req_cnt < 2 || ret_cnt < 2); c++) begin
         applyStimulus(0, 1, 0, '0);
         @(negedge clk);
         if (mem_req && req_cnt < 2) begin
            req_seen[req_cnt] = mem_addr;
            req_cnt++;
         end
         if (inst_valid && ret_cnt < 2) begin
            ret_pc[ret_cnt] = pc;
            ret_cnt++;
         end
      end
      checkOutput("wrap_req_count", req_cnt, 2);
      checkOutput("wrap_ret_count", ret_cnt, 2);
      if (req_cnt == 2) begin
         checkOutput("wrap_req0", req_seen[0], 8'hFF);
         checkOutput("wrap_req1", req_seen[1], 8'h00);
      end
      if (ret_cnt == 2) begin
         checkOutput("wrap_pc0", ret_pc[0], 8'hFF);
         checkOutput("wrap_pc1", ret_pc[1], 8'h00);
      end

      // Fill the queue, then done and jump on the same edge.
      repeat (2) applyStimulus(1, 0, 0, '0);
      repeat (8) applyStimulus(0, 0, 0, '0);
      @(negedge clk);
      checkOutput("full_valid", inst_valid, 1);
      checkOutput("full_no_req", mem_req, 0);
      checkOutput("full_pc", pc, 8'h00);
      applyStimulus(0, 1, 1, 8'h80);
      @(negedge clk);
      checkOutput("full_jump_req", mem_req, 0);
      applyStimulus(0, 0, 0, '0);
      @(negedge clk);
      checkOutput("full_after_valid", inst_valid, 0);
      checkOutput("full_after_req", mem_req, 1);
      checkOutput("full_after_addr", mem_addr, 8'h80);

      // Reset with a request in flight, then a stale response right after.
      lat = 2;
      repeat (2) applyStimulus(1, 0, 0, '0);
      applyStimulus(0, 0, 0, '0);
      @(negedge clk);
      checkOutput("rst_mid_req", mem_req, 1);
      applyStimulus(1, 0, 0, '0);
      applyStimulus(0, 0, 0, '0);
      manual    = 1'b1;
      man_valid = 1'b1;
      man_rdata = 16'hDEAD;
      @(negedge clk);
      checkOutput("rst_mid_valid", inst_valid, 0);
      checkOutput("rst_mid_restart", mem_req, 1);
      checkOutput("rst_mid_addr", mem_addr, RESET_PC);
      applyStimulus(0, 0, 0, '0);
      manual    = 1'b0;
      man_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_stale_dropped", inst_valid, 0);
      checkOutput("rst_stale_pc", pc, RESET_PC);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         applyStimulus(0, 0, 0, '0);
         @(negedge clk);
         if (inst_valid) begin
            found = 1'b1;
            checkOutput("rst_refetch_inst", inst, 16'h2A05);
         end
      end
      checkOutput("rst_refetch_seen", found, 1);

      // Randomized traffic checked by the model every cycle.
      rand_lat = 1'b1;
      repeat (2) applyStimulus(1, 0, 0, '0);
      for (int c = 0; c < 4000; c++) begin
         applyStimulus($urandom_range(199) == 0,
                       $urandom_range(1) == 1,
                       $urandom_range(19) == 0,
                       AW'($urandom));
      end
      applyStimulus(0, 0, 0, '0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
